// File: rtl/riscv_store_buffer_pkg.sv
// Shared RV32 data-memory configuration (XLEN, address width, funct3 codes)
// plus store-buffer entry type and lane helpers.
`ifndef RISCV_CONFIG_DEFS
`define RISCV_CONFIG_DEFS
`define XLEN 32
`define DMEM_ADDR_BIT 16
`define F3_LB  3'b000
`define F3_LH  3'b001
`define F3_LW  3'b010
`define F3_LBU 3'b100
`define F3_LHU 3'b101
`define F3_SB  3'b000
`define F3_SH  3'b001
`define F3_SW  3'b010
`endif

package riscv_store_buffer_pkg;
  localparam int XLEN          = `XLEN;
  localparam int DMEM_ADDR_BIT = `DMEM_ADDR_BIT;
  localparam int WADDR_BIT     = DMEM_ADDR_BIT - 2;
  localparam int NBYTE         = XLEN / 8;

  localparam logic [2:0] F3_LB  = `F3_LB;
  localparam logic [2:0] F3_LH  = `F3_LH;
  localparam logic [2:0] F3_LW  = `F3_LW;
  localparam logic [2:0] F3_LBU = `F3_LBU;
  localparam logic [2:0] F3_LHU = `F3_LHU;
  localparam logic [2:0] F3_SB  = `F3_SB;
  localparam logic [2:0] F3_SH  = `F3_SH;
  localparam logic [2:0] F3_SW  = `F3_SW;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  typedef struct packed {
    logic [WADDR_BIT-1:0] waddr;
    logic [XLEN-1:0]      data;
    logic [NBYTE-1:0]     sel;
  } sb_entry_t;

  // Undefined encodings fall through to a word access.
  function automatic acc_size_e acc_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: acc_size = SZ_BYTE;
      F3_LH, F3_LHU: acc_size = SZ_HALF;
      default:       acc_size = SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (acc_size(f3))
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic sb_entry_t make_entry(input logic [DMEM_ADDR_BIT-1:0] addr,
                                           input logic [2:0] f3,
                                           input logic [XLEN-1:0] wdata);
    sb_entry_t e;
    logic [4:0] sh;
    sh      = {addr[1:0], 3'b000};
    e.waddr = addr[DMEM_ADDR_BIT-1:2];
    case (acc_size(f3))
      SZ_BYTE: begin
        e.data = {{(XLEN-8){1'b0}}, wdata[7:0]} << sh;
        e.sel  = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        e.data = {{(XLEN-16){1'b0}}, wdata[15:0]} << sh;
        e.sel  = 4'b0011 << addr[1:0];
      end
      default: begin
        e.data = wdata;
        e.sel  = 4'b1111;
      end
    endcase
    return e;
  endfunction
endpackage

// File: rtl/riscv_store_buffer_if.sv
// Core request/response and data-memory port bundle of the store buffer.
interface riscv_store_buffer_if;
  import riscv_store_buffer_pkg::*;

  logic                 i_req_valid;
  logic                 o_req_ready;
  logic                 i_req_wr;
  logic [2:0]           i_req_funct3;
  logic [DMEM_ADDR_BIT-1:0] i_req_addr;
  logic [XLEN-1:0]      i_req_wdata;
  logic                 o_rsp_valid;
  logic [XLEN-1:0]      o_rsp_rdata;
  logic                 o_misaligned;
  logic                 o_sb_empty;
  logic [WADDR_BIT-1:0] o_dmem_addr;
  logic [XLEN-1:0]      o_dmem_data;
  logic [NBYTE-1:0]     o_dmem_byte_sel;
  logic                 o_dmem_wr_en;
  logic [XLEN-1:0]      i_dmem_data;

  modport slave (
    input  i_req_valid, i_req_wr, i_req_funct3, i_req_addr, i_req_wdata, i_dmem_data,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_misaligned, o_sb_empty,
           o_dmem_addr, o_dmem_data, o_dmem_byte_sel, o_dmem_wr_en
  );

  modport master (
    output i_req_valid, i_req_wr, i_req_funct3, i_req_addr, i_req_wdata, i_dmem_data,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_misaligned, o_sb_empty,
           o_dmem_addr, o_dmem_data, o_dmem_byte_sel, o_dmem_wr_en
  );
endinterface

// File: rtl/riscv_load_align.sv
// Combinational load lane extraction and sign/zero extension for RV32I loads.
module riscv_load_align
  import riscv_store_buffer_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_byte_off,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_data
);
  logic [XLEN-1:0] shifted;

  // funct3[2] marks the unsigned variants (LBU/LHU).
  always_comb begin
    shifted = i_word >> {i_byte_off, 3'b000};
    case (acc_size(i_funct3))
      SZ_BYTE: o_data = {{(XLEN-8){shifted[7] & ~i_funct3[2]}}, shifted[7:0]};
      SZ_HALF: o_data = {{(XLEN-16){shifted[15] & ~i_funct3[2]}}, shifted[15:0]};
      default: o_data = i_word;
    endcase
  end
endmodule

// File: rtl/riscv_store_buffer.sv
// Store buffer: queues stores in a circular FIFO and drains them to data memory
// whenever no load owns the port; loads hitting a pending word stall (no forwarding).
module riscv_store_buffer
  import riscv_store_buffer_pkg::*;
#(
  parameter int SB_DEPTH = 4
)(
  input logic                 i_clk,
  input logic                 i_rstn,
  riscv_store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(SB_DEPTH);

  sb_entry_t fifo_mem [SB_DEPTH];
  sb_entry_t head, req_entry;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             rsp_valid_q, rsp_valid_d, misaligned_q, misaligned_d;
  logic [XLEN-1:0]  rsp_rdata_q, rsp_rdata_d, load_data;
  logic             req_mis, raw_hazard, req_ready, load_acc, store_acc, drain;

  assign head = fifo_mem[rd_ptr_q];

  riscv_load_align u_load_align (
    .i_funct3   (bus.i_req_funct3),
    .i_byte_off (bus.i_req_addr[1:0]),
    .i_word     (bus.i_dmem_data),
    .o_data     (load_data)
  );

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    raw_hazard = 1'b0;
    for (int j = 0; j < SB_DEPTH; j++) begin
      raw_hazard = raw_hazard |
        (({1'b0, PTR_W'(PTR_W'(j) - rd_ptr_q)} < count_q) &&
         (fifo_mem[j].waddr == bus.i_req_addr[DMEM_ADDR_BIT-1:2]));
    end
  end

  // Request acceptance, port arbitration and next-state computation.
  always_comb begin
    req_entry = make_entry(bus.i_req_addr, bus.i_req_funct3, bus.i_req_wdata);
    req_mis   = is_misaligned(bus.i_req_funct3, bus.i_req_addr[1:0]);
    if (!i_rstn) begin
      req_ready = 1'b0;
    end else if (req_mis) begin
      req_ready = 1'b1;
    end else if (bus.i_req_wr) begin
      req_ready = (count_q < FULL_CNT);
    end else begin
      req_ready = ~raw_hazard;
    end
    load_acc  = bus.i_req_valid & req_ready & ~bus.i_req_wr & ~req_mis;
    store_acc = bus.i_req_valid & req_ready &  bus.i_req_wr & ~req_mis;
    drain     = i_rstn & (count_q != '0) & ~load_acc;

    wr_ptr_d = store_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = drain     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({store_acc, drain})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    rsp_valid_d  = load_acc;
    rsp_rdata_d  = load_acc ? load_data : rsp_rdata_q;
    misaligned_d = bus.i_req_valid & req_mis;
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      misaligned_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (store_acc) begin
      fifo_mem[wr_ptr_q] <= req_entry;
    end
  end

  assign bus.o_req_ready     = req_ready;
  assign bus.o_rsp_valid     = rsp_valid_q;
  assign bus.o_rsp_rdata     = rsp_rdata_q;
  assign bus.o_misaligned    = misaligned_q;
  assign bus.o_sb_empty      = (count_q == '0);
  assign bus.o_dmem_addr     = load_acc ? bus.i_req_addr[DMEM_ADDR_BIT-1:2] : head.waddr;
  assign bus.o_dmem_data     = head.data;
  assign bus.o_dmem_byte_sel = head.sel;
  assign bus.o_dmem_wr_en    = drain;
endmodule

// File: tb/tb_riscv_store_buffer.sv
// Randomized self-checking bench: a queue-and-memory reference model predicts every
// cycle's handshake, memory port and response; directed cases pin literal values.
module tb_riscv_store_buffer;
  import riscv_store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  riscv_store_buffer_if bus();
  riscv_store_buffer #(.SB_DEPTH(DEPTH)) dut (.i_clk(clk), .i_rstn(rstn), .bus(bus.slave));

  typedef struct {
    int          wa;
    logic [31:0] data;
    logic [3:0]  sel;
  } mentry_t;

  logic [31:0] tb_mem  [0:16383];
  logic [31:0] ref_mem [0:16383];
  mentry_t     q[$];
  int          wr_log[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic        chk_en = 1'b0;

  logic        d_rstn = 1'b0, d_v = 1'b0, d_w = 1'b0, d_mis = 1'b0;
  logic [2:0]  d_f3 = 3'd0;
  int          d_addr = 0;
  logic [31:0] d_wd = 32'd0;
  logic        d_load_acc = 1'b0, d_store_acc = 1'b0;
  logic        exp_ready = 1'b0, exp_wr = 1'b0, exp_rv = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_rdata = 32'd0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] bmask(input logic [3:0] sel);
    logic [31:0] m = 32'd0;
    for (int b = 0; b < 4; b++) if (sel[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic int msize(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic mentry_t model_entry(input int addr, input logic [2:0] f3,
                                          input logic [31:0] wd);
    mentry_t e;
    int      sz = msize(f3);
    longint  m  = (64'd1 << (8*sz)) - 64'd1;
    e.wa   = addr / 4;
    e.sel  = 4'(((1 << sz) - 1) << (addr % 4));
    e.data = 32'((longint'(wd) & m) << (8*(addr % 4)));
    return e;
  endfunction

  function automatic logic [31:0] model_load(input int addr, input logic [2:0] f3);
    int     sz = msize(f3);
    longint m  = (64'd1 << (8*sz)) - 64'd1;
    longint v;
    v = (longint'(ref_mem[addr/4]) >> (8*(addr % 4))) & m;
    if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  assign bus.i_dmem_data = tb_mem[bus.o_dmem_addr];

  always @(posedge clk) begin
    if (bus.o_dmem_wr_en) begin
      tb_mem[bus.o_dmem_addr] <= merge(tb_mem[bus.o_dmem_addr], bus.o_dmem_data, bus.o_dmem_byte_sel);
      wr_log.push_back(int'(bus.o_dmem_addr));
    end
  end

  // Apply the previous cycle's predicted effects at the clock edge.
  task automatic commit();
    if (!d_rstn) begin
      q.delete();
      exp_rv = 1'b0; exp_mis = 1'b0; exp_rdata = 32'd0;
    end else begin
      exp_mis = d_v && d_mis;
      exp_rv  = d_load_acc;
      if (d_load_acc) exp_rdata = model_load(d_addr, d_f3);
      if (exp_wr) begin
        ref_mem[q[0].wa] = merge(ref_mem[q[0].wa], q[0].data, q[0].sel);
        void'(q.pop_front());
      end
      if (d_store_acc) q.push_back(model_entry(d_addr, d_f3, d_wd));
    end
  endtask

  task automatic decide();
    logic hit = 1'b0;
    foreach (q[i]) if (q[i].wa == d_addr / 4) hit = 1'b1;
    d_mis = (d_addr % msize(d_f3)) != 0;
    if (!d_rstn)    exp_ready = 1'b0;
    else if (d_mis) exp_ready = 1'b1;
    else if (d_w)   exp_ready = (q.size() < DEPTH);
    else            exp_ready = !hit;
    d_load_acc  = d_v && exp_ready && !d_w && !d_mis;
    d_store_acc = d_v && exp_ready &&  d_w && !d_mis;
    exp_wr      = d_rstn && (q.size() > 0) && !d_load_acc;
  endtask

  task automatic cyc(input logic rn, input logic v, input logic w, input logic [2:0] f3,
                     input logic [15:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    commit();
    rstn = rn; bus.i_req_valid = v; bus.i_req_wr = w; bus.i_req_funct3 = f3;
    bus.i_req_addr = a; bus.i_req_wdata = wd;
    d_rstn = rn; d_v = v; d_w = w; d_f3 = f3; d_addr = int'(a); d_wd = wd;
    decide();
    chk_en = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 32'd0);
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(bus.o_req_ready), 32'(exp_ready));
      chk("dmem_wr_en", 32'(bus.o_dmem_wr_en), 32'(exp_wr));
      if (exp_wr) begin
        chk("drain_addr", 32'(bus.o_dmem_addr), 32'(q[0].wa));
        chk("drain_sel", 32'(bus.o_dmem_byte_sel), 32'(q[0].sel));
        chk("drain_data", bus.o_dmem_data & bmask(q[0].sel), q[0].data & bmask(q[0].sel));
      end
      if (d_load_acc) chk("load_addr", 32'(bus.o_dmem_addr), 32'(d_addr / 4));
      chk("sb_empty", 32'(bus.o_sb_empty), 32'(q.size() == 0));
      chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(exp_rv));
      chk("misaligned", 32'(bus.o_misaligned), 32'(exp_mis));
      if (exp_rv) chk("rsp_rdata", bus.o_rsp_rdata, exp_rdata);
    end
  end

  initial begin
    int last_a = 0;
    rstn = 1'b0;
    bus.i_req_valid = 1'b0; bus.i_req_wr = 1'b0; bus.i_req_funct3 = 3'd0;
    bus.i_req_addr = 16'd0; bus.i_req_wdata = 32'd0;
    for (int i = 0; i < 16384; i++) begin
      tb_mem[i] <= 32'd0;
      ref_mem[i] = 32'd0;
    end
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 32'd0);
    idle(); #2;
    chk("reset_empty", 32'(bus.o_sb_empty), 32'd1);
    chk("reset_rdata", bus.o_rsp_rdata, 32'd0);

    // SB to 0x103 lands in the top byte lane of word 0x40.
    cyc(1'b1, 1'b1, 1'b1, F3_SB, 16'h0103, 32'h0000_00AA);
    idle(); #2;
    chk("sb_wr_en", 32'(bus.o_dmem_wr_en), 32'd1);
    chk("sb_addr", 32'(bus.o_dmem_addr), 32'h40);
    chk("sb_sel", 32'(bus.o_dmem_byte_sel), 32'b1000);
    chk("sb_data", bus.o_dmem_data, 32'hAA00_0000);

    // Load to a pending word stalls until the store drains.
    cyc(1'b1, 1'b1, 1'b1, F3_SW, 16'h0080, 32'hDEAD_BEEF);
    cyc(1'b1, 1'b1, 1'b0, F3_LW, 16'h0080, 32'd0); #2;
    chk("raw_stall", 32'(bus.o_req_ready), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, F3_LW, 16'h0080, 32'd0); #2;
    chk("raw_accept", 32'(bus.o_req_ready), 32'd1);
    idle(); #2;
    chk("raw_rsp_valid", 32'(bus.o_rsp_valid), 32'd1);
    chk("raw_rdata", bus.o_rsp_rdata, 32'hDEAD_BEEF);

    // Sign/zero extension on word 0x00008081.
    cyc(1'b1, 1'b1, 1'b1, F3_SW, 16'h0000, 32'h0000_8081);
    idle();
    cyc(1'b1, 1'b1, 1'b0, F3_LB, 16'h0000, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, F3_LBU, 16'h0001, 32'd0); #2;
    chk("lb_ext", bus.o_rsp_rdata, 32'hFFFF_FF81);
    cyc(1'b1, 1'b1, 1'b0, F3_LH, 16'h0000, 32'd0); #2;
    chk("lbu_ext", bus.o_rsp_rdata, 32'h0000_0080);
    idle(); #2;
    chk("lh_ext", bus.o_rsp_rdata, 32'hFFFF_8081);

    // Misaligned word load: pulse only, no response or write.
    cyc(1'b1, 1'b1, 1'b0, F3_LW, 16'h0102, 32'd0); #2;
    chk("mis_ready", 32'(bus.o_req_ready), 32'd1);
    idle(); #2;
    chk("mis_pulse", 32'(bus.o_misaligned), 32'd1);
    chk("mis_no_rsp", 32'(bus.o_rsp_valid), 32'd0);
    chk("mis_no_wr", 32'(bus.o_dmem_wr_en), 32'd0);
    idle(); #2;
    chk("mis_one_cycle", 32'(bus.o_misaligned), 32'd0);

    // Five back-to-back word stores reach memory in program order.
    wr_log.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, F3_SW, 16'(16 + 4*i), 32'h1000 + i);
    idle(); idle(); #2;
    chk("burst_count", 32'(wr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
      chk("burst_order", 32'(wr_log[i]), 32'(4 + i));
      chk("burst_data", tb_mem[4+i], 32'h1000 + i);
    end

    // Reset discards a pending store.
    cyc(1'b1, 1'b1, 1'b1, F3_SW, 16'h0030, 32'h5555_5555);
    cyc(1'b0, 1'b1, 1'b1, F3_SW, 16'h0034, 32'h6666_6666); #2;
    chk("rst_wr_en", 32'(bus.o_dmem_wr_en), 32'd0);
    chk("rst_ready", 32'(bus.o_req_ready), 32'd0);
    idle(); #2;
    chk("rst_empty", 32'(bus.o_sb_empty), 32'd1);
    chk("rst_rdata", bus.o_rsp_rdata, 32'd0);
    idle(); idle(); #2;
    chk("rst_no_write", tb_mem[12], 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0]  f3;
      logic        w, v, rn;
      int          a;
      w  = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      rn = ($urandom_range(0, 99) != 0);
      f3 = 3'($urandom_range(0, 7));
      if (w && (f3 == 3'd4 || f3 == 3'd5)) f3 = F3_SW;
      a = (!w && $urandom_range(0, 1) == 1) ? last_a : int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = a - (a % msize(f3));
      if (w) last_a = a;
      cyc(rn, v, w, f3, 16'(a), $urandom);
    end
    idle(); idle(); idle();
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
